// File: rtl/prog_rom_loader.sv
// prog_rom_loader
//   Synchronous-read program memory (DW x 2**AW) with a streaming load port.
//   A host or UART bootloader streams a program in through the load port while
//   the CPU is held in reset; the CPU fetch path reads through address/out.
//
// Parameters
//   DW        instruction word width
//   AW        address width, DEPTH = 2**AW words
//   INIT_ZERO 1: memory powers up all-zero, 0: power-up contents undefined
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   address / out           CPU fetch address, registered instruction (1 cycle)
//   load_start              pulse in IDLE to begin a new program load
//   load_valid / load_ready word handshake, accepted when both are high
//   load_data / load_last   program word and final-data-word marker
//   load_busy               load in progress
//   load_done               one-cycle pulse at the end of a load
//   load_count              data words written by the current or last load
//   cpu_hold                CPU reset request, high from load start to DONE
//   load_err                sticky checksum mismatch
//
// Build option
//   PROG_ROM_CHECKSUM_EN    when defined, each load is followed by one checksum
//                           word; sum of data + checksum must be 0 mod 2**DW.
//                           When undefined, load_err is tied low.

module prog_rom_loader #(
  parameter int DW        = 16,
  parameter int AW        = 15,
  parameter int INIT_ZERO = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] address,
  output logic [DW-1:0] out,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic          load_busy,
  output logic          load_done,
  output logic [AW:0]   load_count,
  output logic          cpu_hold,
  output logic          load_err
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd3;
`ifdef PROG_ROM_CHECKSUM_EN
  localparam logic [1:0] CHECK     = 2'd2;
  localparam logic [1:0] LOAD_EXIT = CHECK;
`else
  localparam logic [1:0] LOAD_EXIT = DONE;
`endif

  // Power-up contents come from the declaration; reset never touches memory.
  logic [DW-1:0] mem [DEPTH] = '{default: (INIT_ZERO != 0) ? {DW{1'b0}} : {DW{1'bx}}};

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr;
  logic          in_load;
  logic          accept;
  logic          data_acc;
  logic          load_end;

  function automatic logic [AW:0] count_inc(input logic [AW:0] c);
    if (c == DEPTH_CNT) return c;
    return c + (AW+1)'(1);
  endfunction

`ifdef PROG_ROM_CHECKSUM_EN
  assign in_load = (state == LOAD) || (state == CHECK);
`else
  assign in_load = (state == LOAD);
`endif

  assign load_ready = in_load;
  assign load_busy  = in_load;
  assign load_done  = (state == DONE);
  assign cpu_hold   = (state != IDLE);

  assign accept   = load_valid & load_ready;
  assign data_acc = accept & (state == LOAD);
  // The top word ends the load exactly like load_last, so the pointer never wraps.
  assign load_end = data_acc & (load_last | (wr_ptr == {AW{1'b1}}));

  // Control path
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      load_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            load_count <= '0;
          end
        end
        LOAD: begin
          if (data_acc) begin
            if (wr_ptr != {AW{1'b1}}) wr_ptr <= wr_ptr + AW'(1);
            load_count <= count_inc(load_count);
            if (load_end) state <= LOAD_EXIT;
          end
        end
`ifdef PROG_ROM_CHECKSUM_EN
        CHECK: begin
          if (accept) state <= DONE;
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PROG_ROM_CHECKSUM_EN
  logic [DW-1:0] sum_p0;
  logic          err_q;

  function automatic logic csum_bad(input logic [DW-1:0] s, input logic [DW-1:0] w);
    logic [DW-1:0] t;
    t = s + w;
    return (t != '0);
  endfunction

  // Running sum of accepted data words, restarted by each load_start
  always_ff @(posedge clock) begin
    if (state == IDLE && load_start) sum_p0 <= '0;
    else if (data_acc)               sum_p0 <= sum_p0 + load_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state == IDLE && load_start) begin
      err_q <= 1'b0;
    end else if (state == CHECK && accept && csum_bad(sum_p0, load_data)) begin
      err_q <= 1'b1;
    end
  end

  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

  // Write port
  always_ff @(posedge clock) begin
    if (data_acc) mem[wr_ptr] <= load_data;
  end

  // Fetch path: outside IDLE the CPU is held, so feed it a harmless zero word
  always_ff @(posedge clock or posedge reset) begin
    if (reset)              out <= '0;
    else if (state != IDLE) out <= '0;
    else                    out <= mem[address];
  end

endmodule
